ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction prefetch queue between PC generation/instruction memory and the decode stage of riscv_pipeline.
//  Owns PC_F, issues one word-aligned read per cycle to a 1-cycle-latency IMEM, buffers returned words with their PC.
//  Presents the head entry to decode and honours decode stall; flushes on taken branch/jump from execute.
// PARAMETERS
//  DEPTH     4     queue entries; power of 2, >= 2
//  XLEN      32    instruction/PC width
//  IMEM_AW   8     IMEM word-address width (256 words, index = PC[IMEM_AW+1:2])
//  RESET_PC  32'h0 PC_F value after reset
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  stall_D      in   1        decode cannot accept head entry this cycle
//  PCSrc_E      in   1        taken branch/jump in execute: flush and redirect
//  PC_Target_E  in   XLEN     redirect target
//  imem_req     out  1        read request this cycle
//  imem_addr    out  IMEM_AW  word address of request
//  imem_rdata   in   XLEN     read data, valid the cycle after imem_req
//  valid_D      out  1        Instr_D/PC_D/PCPlus4_D hold a real instruction
//  Instr_D      out  XLEN     head instruction; 32'h00000013 (NOP) when !valid_D
//  PC_D         out  XLEN     PC of head instruction; 0 when !valid_D
//  PCPlus4_D    out  XLEN     PC_D + 4; 0 when !valid_D
//  PC_F         out  XLEN     next fetch PC
//  q_count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-operation): PC_F=RESET_PC, queue empty, in-flight killed, imem_req=0,
//    valid_D=0, Instr_D=NOP, PC_D=0, PCPlus4_D=0, q_count=0. State returns to reset values immediately.
//  - Issue: imem_req = !rst & !PCSrc_E & (q_count + inflight < DEPTH). On issue: imem_addr=PC_F[IMEM_AW+1:2],
//    inflight<=1, inflight_pc<=PC_F, PC_F<=PC_F+4 (mod 2^XLEN; IMEM index wraps naturally).
//  - Response: cycle after issue, if inflight & !kill, {imem_rdata, inflight_pc} enqueued at tail.
//  - Dequeue: head retired at edge when valid_D & !stall_D. Enqueue and dequeue in same cycle allowed at any
//    occupancy; q_count unchanged. Pointers wrap mod DEPTH.
//  - Full: no issue while q_count+inflight==DEPTH; never overwrite an entry, never drop a response.
//  - Empty: valid_D=0, output defaults as at reset.
//  - Flush (PCSrc_E=1): valid_D forced 0 that cycle; at edge queue cleared, in-flight response discarded,
//    PC_F<=PC_Target_E with bits[1:0] forced 00. First target fetch issued next cycle.
//    Flush beats stall_D and beats a simultaneous response/dequeue.
//  - Latency (no bypass): first imem_req in cycle 0 after rst falls; data in cycle 1; valid_D=1 in cycle 2.
//    Flush-to-valid_D = 3 cycles (flush cycle, issue, response, valid).
//  - Steady state with stall_D=0: one instruction per cycle to decode.
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: when queue empty, response arriving, !kill, !PCSrc_E, imem_rdata/inflight_pc drive
//    decode outputs directly with valid_D=1 the same cycle; if !stall_D word is consumed and not enqueued,
//    else it is enqueued. Reset-to-valid_D = 2 cycles (1 + fetch), flush-to-valid_D = 2 after flush.
//  Not defined: all responses go through the queue; latencies as in BEHAVIOUR.
// TESTING
//  1 IMEM[0..3]=00500093,00300113,002081B3,00000013; release rst, stall_D=0 -> valid_D at cycle 2,
//    PC_D=0,4,8,C on consecutive cycles, Instr_D matches IMEM, PCPlus4_D=PC_D+4.
//  2 stall_D=1 from cycle 2 for 6 cycles -> q_count saturates at 4, imem_req=0 while full, PC_F=0x10;
//    release -> PC_D 0,4,8,C,10 with no gap or duplicate.
//  3 PCSrc_E=1, PC_Target_E=0x40 while 3 entries queued and 1 in flight -> valid_D=0 same cycle, q_count=0
//    next edge, imem_addr=0x10 next cycle, next valid PC_D=0x40; discarded words never appear.
//  4 PCSrc_E=1 with stall_D=1 and PC_Target_E=0x22 -> flush occurs, redirect to 0x20.
//  5 Assert rst mid-stream with 2 entries queued -> outputs to reset values without a clock edge;
//    restart fetches from RESET_PC.
//  6 PC_F=0xFFFFFFFC -> next PC_F=0x00000000, imem_addr wraps to 0; with FETCHQ_BYPASS_EN, case 1 yields
//    valid_D at cycle 1.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between PC generation / IMEM and decode.
// Owns PC_F, issues one word read per cycle to a 1-cycle IMEM, buffers {instr, pc}
// pairs in a DEPTH-entry ring and hands the head to decode under stall/flush control.
// Optional feature macro: FETCHQ_BYPASS_EN -- when the queue is empty, a returning
// IMEM word is presented to decode in the same cycle it arrives.
module ifetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = 32,
   parameter int              IMEM_AW  = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_D,
   input  logic                   PCSrc_E,
   input  logic [XLEN-1:0]        PC_Target_E,
   output logic                   imem_req,
   output logic [IMEM_AW-1:0]     imem_addr,
   input  logic [XLEN-1:0]        imem_rdata,
   output logic                   valid_D,
   output logic [XLEN-1:0]        Instr_D,
   output logic [XLEN-1:0]        PC_D,
   output logic [XLEN-1:0]        PCPlus4_D,
   output logic [XLEN-1:0]        PC_F,
   output logic [$clog2(DEPTH):0] q_count
);
   localparam int              PW  = $clog2(DEPTH);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] q_instr [DEPTH];
   logic [XLEN-1:0] q_pc    [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [PW:0]     count;
   logic            inflight;
   logic [XLEN-1:0] inflight_pc;
   logic [PW+1:0]   occ;
   logic            q_empty, resp, byp, enq, deq;
   logic            unused_tgt_lsb;

   // Target low bits are dropped: fetch is always word aligned.
   assign unused_tgt_lsb = ^PC_Target_E[1:0];

   assign q_count = count;
   assign q_empty = (count == '0);
   // A flush in the response cycle kills the returning word.
   assign resp    = inflight & ~PCSrc_E;
   // Reserve a slot for the in-flight word so a response is never dropped.
   assign occ       = {1'b0, count} + (PW+2)'(inflight);
   assign imem_req  = ~rst & ~PCSrc_E & (occ < (PW+2)'(DEPTH));
   assign imem_addr = PC_F[IMEM_AW+1:2];

`ifdef FETCHQ_BYPASS_EN
   assign byp = q_empty & resp;
`else
   assign byp = 1'b0;
`endif

   assign valid_D = byp | (~q_empty & ~PCSrc_E);
   // Queue head retires only when it is the one being shown to decode.
   assign deq     = ~q_empty & ~PCSrc_E & ~stall_D;
   // A bypassed word that decode accepts never lands in the queue.
   assign enq     = resp & ~(byp & ~stall_D);

   // Decode-side mux: bypass word, queue head, or NOP/zero defaults.
   always_comb begin
      Instr_D   = NOP;
      PC_D      = '0;
      PCPlus4_D = '0;
      if (byp) begin
         Instr_D = imem_rdata;
         PC_D    = inflight_pc;
      end else if (valid_D) begin
         Instr_D = q_instr[rd_ptr];
         PC_D    = q_pc[rd_ptr];
      end
      if (valid_D) PCPlus4_D = PC_D + XLEN'(4);
   end

   // Control state: fetch PC, in-flight tracking, ring pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC_F        <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (PCSrc_E) begin
         PC_F     <= {PC_Target_E[XLEN-1:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= PC_F;
            PC_F        <= PC_F + XLEN'(4);
         end
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(enq) - (PW+1)'(deq);
      end
   end

   // Entry storage; contents are only meaningful below count so no reset needed.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= inflight_pc;
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table for start-up/stall, hand sequences
// for flush, redirect alignment, PC wrap and async reset, then randomized traffic
// compared against a queue-based reference model.
module tb_ifetch_queue;
`ifdef FETCHQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst = 1'b1, stall_D = 1'b0, PCSrc_E = 1'b0;
   logic [31:0] PC_Target_E = '0;
   logic        imem_req, valid_D;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata, Instr_D, PC_D, PCPlus4_D, PC_F;
   logic [2:0]  q_count;
   logic [31:0] mem [256];
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   // 1-cycle latency IMEM
   always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

   ifetch_queue #(.DEPTH(DEPTH), .XLEN(32), .IMEM_AW(8), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_D(stall_D), .PCSrc_E(PCSrc_E),
      .PC_Target_E(PC_Target_E), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .valid_D(valid_D), .Instr_D(Instr_D), .PC_D(PC_D),
      .PCPlus4_D(PCPlus4_D), .PC_F(PC_F), .q_count(q_count));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return mem[pc[9:2]];
   endfunction

   // one cycle: drive at negedge, sample 1 time unit later
   task automatic cyc(input logic s, input logic f, input logic [31:0] t);
      @(negedge clk);
      stall_D = s; PCSrc_E = f; PC_Target_E = t;
      #1;
   endtask

   typedef struct {
      logic        stall;
      logic        v;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        req;
      logic [31:0] pcf;
   } vec_t;
   vec_t tbl [13];

   // reference model state
   logic [31:0] m_q [$];
   bit          m_inf;
   logic [31:0] m_ipc, m_pcf;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, k;
      bit e_byp, e_v, e_req, resp;
      logic [31:0] e_pc;

      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[0] = 32'h00500093; mem[1] = 32'h00300113;
      mem[2] = 32'h002081B3; mem[3] = 32'h00000013;

      // stall, valid, pc, count, req, pc_f  (cycle 0 = first cycle after reset release)
      tbl[0]  = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b1, 32'h00};
      tbl[1]  = '{1'b0, 1'b0, 32'h00, 3'd0, 1'b1, 32'h04};
      tbl[2]  = '{1'b1, 1'b1, 32'h00, 3'd1, 1'b1, 32'h08};
      tbl[3]  = '{1'b1, 1'b1, 32'h00, 3'd2, 1'b1, 32'h0C};
      tbl[4]  = '{1'b1, 1'b1, 32'h00, 3'd3, 1'b0, 32'h10};
      tbl[5]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0, 32'h10};
      tbl[6]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0, 32'h10};
      tbl[7]  = '{1'b1, 1'b1, 32'h00, 3'd4, 1'b0, 32'h10};
      tbl[8]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0, 32'h10};
      tbl[9]  = '{1'b0, 1'b1, 32'h04, 3'd3, 1'b1, 32'h10};
      tbl[10] = '{1'b0, 1'b1, 32'h08, 3'd2, 1'b1, 32'h14};
      tbl[11] = '{1'b0, 1'b1, 32'h0C, 3'd2, 1'b1, 32'h18};
      tbl[12] = '{1'b0, 1'b1, 32'h10, 3'd2, 1'b1, 32'h1C};

      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", valid_D, 32'h0);
      chk("reset_instr", Instr_D, 32'h13);
      chk("reset_req", imem_req, 32'h0);

`ifndef FETCHQ_BYPASS_EN
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         rst = 1'b0;
         stall_D = tbl[i].stall;
         #1;
         chk($sformatf("tbl%0d_valid", i), valid_D, tbl[i].v);
         chk($sformatf("tbl%0d_pc", i), PC_D, tbl[i].v ? tbl[i].pc : 32'h0);
         chk($sformatf("tbl%0d_instr", i), Instr_D, tbl[i].v ? word_at(tbl[i].pc) : 32'h13);
         chk($sformatf("tbl%0d_pc4", i), PCPlus4_D, tbl[i].v ? tbl[i].pc + 32'd4 : 32'h0);
         chk($sformatf("tbl%0d_cnt", i), q_count, tbl[i].cnt);
         chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
         chk($sformatf("tbl%0d_pcf", i), PC_F, tbl[i].pcf);
         if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, {24'h0, tbl[i].pcf[9:2]});
      end
`else
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("byp_c0_valid", valid_D, 32'h0);
      chk("byp_c0_req", imem_req, 32'h1);
      for (int i = 1; i < 5; i++) begin
         cyc(1'b0, 1'b0, 32'h0);
         chk($sformatf("byp_c%0d_valid", i), valid_D, 32'h1);
         chk($sformatf("byp_c%0d_pc", i), PC_D, 32'((i - 1) * 4));
         chk($sformatf("byp_c%0d_instr", i), Instr_D, word_at(32'((i - 1) * 4)));
      end
`endif

      // flush with entries queued and a word in flight
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'h40);
      chk("flush_valid", valid_D, 32'h0);
      chk("flush_req", imem_req, 32'h0);
      chk("flush_pc", PC_D, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      chk("flush_cnt", q_count, 32'h0);
      chk("flush_req2", imem_req, 32'h1);
      chk("flush_addr", imem_addr, 32'h10);
      lat = 0;
      do begin cyc(1'b0, 1'b0, 32'h0); lat++; end while (!valid_D && lat < 8);
      chk("flush_lat", 32'(lat), BYP ? 32'd1 : 32'd2);
      chk("flush_tgt_pc", PC_D, 32'h40);
      chk("flush_tgt_instr", Instr_D, word_at(32'h40));
      cyc(1'b0, 1'b0, 32'h0);
      chk("flush_next_pc", PC_D, 32'h44);

      // flush beats stall; target low bits dropped
      cyc(1'b1, 1'b1, 32'h22);
      chk("fstall_valid", valid_D, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      chk("redir_pcf", PC_F, 32'h20);
      chk("redir_addr", imem_addr, 32'h08);
      chk("redir_cnt", q_count, 32'h0);

      // PC wrap at top of address space
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b0, 32'h0);
      chk("wrap_pcf", PC_F, 32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr, 32'hFF);
      cyc(1'b0, 1'b0, 32'h0);
      chk("wrap_pcf2", PC_F, 32'h0);
      chk("wrap_addr2", imem_addr, 32'h0);

      // async reset mid-stream with two entries queued
      k = 0;
      do begin cyc(1'b1, 1'b0, 32'h0); k++; end while (q_count != 3'd2 && k < 10);
      chk("pre_rst_cnt", q_count, 32'h2);
      rst = 1'b1;
      #1;
      chk("arst_valid", valid_D, 32'h0);
      chk("arst_cnt", q_count, 32'h0);
      chk("arst_req", imem_req, 32'h0);
      chk("arst_pcf", PC_F, 32'h0);
      chk("arst_instr", Instr_D, 32'h13);
      chk("arst_pc", PC_D, 32'h0);
      chk("arst_pc4", PCPlus4_D, 32'h0);
      @(negedge clk);

      // randomized traffic against the reference model
      m_q.delete(); m_inf = 1'b0; m_ipc = '0; m_pcf = 32'h0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         rst = 1'b0;
         stall_D = ($urandom_range(0, 3) == 0);
         PCSrc_E = ($urandom_range(0, 15) == 0);
         PC_Target_E = (n % 2 == 1) ? $urandom : ($urandom & 32'h3FF);
         #1;
         e_byp = BYP && (m_q.size() == 0) && m_inf && !PCSrc_E;
         e_v   = e_byp || (m_q.size() > 0 && !PCSrc_E);
         e_pc  = !e_v ? 32'h0 : (e_byp ? m_ipc : m_q[0]);
         e_req = !PCSrc_E && (m_q.size() + int'(m_inf) < DEPTH);
         chk("rnd_valid", valid_D, e_v);
         chk("rnd_pc", PC_D, e_pc);
         chk("rnd_instr", Instr_D, e_v ? word_at(e_pc) : 32'h13);
         chk("rnd_pc4", PCPlus4_D, e_v ? e_pc + 32'd4 : 32'h0);
         chk("rnd_cnt", q_count, 32'(m_q.size()));
         chk("rnd_req", imem_req, e_req);
         chk("rnd_pcf", PC_F, m_pcf);
         if (e_req) chk("rnd_addr", imem_addr, {24'h0, m_pcf[9:2]});
         // advance model across the clock edge
         resp = m_inf && !PCSrc_E;
         if (PCSrc_E) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pcf = {PC_Target_E[31:2], 2'b00};
         end else begin
            if (e_byp) begin
               if (stall_D) m_q.push_back(m_ipc);
            end else begin
               if (m_q.size() > 0 && !stall_D) void'(m_q.pop_front());
               if (resp) m_q.push_back(m_ipc);
            end
            m_inf = e_req;
            if (e_req) begin
               m_ipc = m_pcf;
               m_pcf = m_pcf + 32'd4;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
